if_prefetch_unit: RTL

Parametrised instruction-fetch stage that replaces the single-entry fetch stage with a decoupled prefetcher. It drives a request/response instruction SRAM-like bus with up to MAX_OUTSTANDING requests in flight and buffers returned instructions in a QUEUE_DEPTH-entry FIFO. It presents {pc, inst} to ID with a valid/allow-in handshake. Exception, ertn and branch redirects cancel in-flight responses and drain the queue.

---
 rtl/if_prefetch_unit_pkg.sv | 26 ++
 rtl/if_prefetch_unit_fetch_fifo.sv | 66 ++++++
 rtl/if_prefetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the decoupled instruction prefetcher.
// Redirect priority: exception/ertn over branch.
package if_prefetch_unit_pkg;

  localparam int         IF_TO_ID_BUS_SIZE   = 64;
  localparam logic [1:0] INST_SRAM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_EXCP,
    REDIR_BRANCH
  } redir_src_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_to_id_t;

  function automatic redir_src_e redir_select(input logic excp, input logic ertn,
                                              input logic br);
    if (excp | ertn) return REDIR_EXCP;
    if (br) return REDIR_BRANCH;
    return REDIR_NONE;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight from
// registered storage, so a push becomes visible one cycle later.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_unit.sv
// Decoupled instruction prefetcher: keeps up to MAX_OUTSTANDING fetches in
// flight, buffers responses in a queue, and discards responses made stale by redirects.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_allow_in,
  input  logic                         br_taken,
  input  logic [31:0]                  br_target,
  input  logic                         excp_flush,
  input  logic                         ertn_flush,
  input  logic [31:0]                  ex_entry,
  output logic                         inst_sram_req,
  output logic                         inst_sram_wr,
  output logic [1:0]                   inst_sram_size,
  output logic [3:0]                   inst_sram_wstrb,
  output logic [31:0]                  inst_sram_addr,
  output logic [31:0]                  inst_sram_wdata,
  input  logic                         inst_sram_addr_ok,
  input  logic                         inst_sram_data_ok,
  input  logic [31:0]                  inst_sram_rdata,
  output logic                         if_to_id_valid,
  output logic [IF_TO_ID_BUS_SIZE-1:0] if_to_id_bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(QUEUE_DEPTH + 1);

  redir_src_e  w_redir_src;
  logic        w_redirect;
  logic [31:0] w_redirect_target;
  logic [31:0] r_fetch_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_cancel;
  logic [OW-1:0] w_outstanding_next;
  logic        w_credit_ok;
  logic        w_accept;
  logic        w_drop;
  logic        w_keep;
  logic        w_pop;
  logic [31:0] w_pend_pc;
  logic        w_pend_full;
  logic        w_pend_empty;
  logic [OW-1:0] w_pend_count;
  if_to_id_t   w_q_wdata;
  logic        w_q_full;
  logic        w_q_empty;
  logic [QW-1:0] w_q_count;
  logic        w_unused;

  assign w_redir_src       = redir_select(excp_flush, ertn_flush, br_taken);
  assign w_redirect        = (w_redir_src != REDIR_NONE);
  assign w_redirect_target = (w_redir_src == REDIR_EXCP) ? ex_entry : br_target;

  // Cancelled responses still count as outstanding, so the credit check stays conservative.
  assign w_credit_ok = (r_outstanding < OW'(MAX_OUTSTANDING)) &&
                       ((32'(r_outstanding) + 32'(w_q_count)) < 32'(QUEUE_DEPTH));

  assign inst_sram_req   = ~reset & ~w_redirect & w_credit_ok;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = INST_SRAM_SIZE_WORD;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign w_accept = inst_sram_req & inst_sram_addr_ok;
  assign w_drop   = inst_sram_data_ok & (r_cancel != '0);
  assign w_keep   = inst_sram_data_ok & ~w_drop & ~w_redirect;
  assign w_pop    = ~w_q_empty & id_allow_in;

  always_comb begin
    w_outstanding_next = r_outstanding;
    case ({w_accept, inst_sram_data_ok})
      2'b10:   w_outstanding_next = r_outstanding + OW'(1);
      2'b01:   w_outstanding_next = r_outstanding - OW'(1);
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_cancel      <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_target;
        r_cancel   <= w_outstanding_next;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop) r_cancel <= r_cancel - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_pop   (w_keep),
    .i_flush (w_redirect),
    .i_wdata (r_fetch_pc),
    .o_rdata (w_pend_pc),
    .o_full  (w_pend_full),
    .o_empty (w_pend_empty),
    .o_count (w_pend_count)
  );

  assign w_q_wdata = '{pc: w_pend_pc, inst: inst_sram_rdata};

  fetch_fifo #(
    .WIDTH (IF_TO_ID_BUS_SIZE),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_wdata (w_q_wdata),
    .o_rdata (if_to_id_bus),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  assign if_to_id_valid = ~w_q_empty;

  assign w_unused = ^{w_pend_full, w_pend_empty, w_pend_count, w_q_full};

endmodule
